controle_calculadora: RTL and testbench
=======================================

CONTROLE_CALCULADORA -- requirements
Module: controle_calculadora

Interface
REQ-001 The block SHALL have parameter LARGURA, default 8, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter CODIGO_MAX, default 3'b100, giving the highest legal operation code.
REQ-003 Port clk, input, 1, is the single clock; all state updates SHALL occur on its rising edge.
REQ-004 Port rst, input, 1, is the reset; it is asynchronous and active-high.
REQ-005 Port dado, input, LARGURA, carries the entry value (operand A, operand B or operation code).
REQ-006 Port dado_valido, input, 1, means dado holds a valid entry.
REQ-007 Port dado_pronto, output, 1, means the block accepts an entry this cycle.
REQ-008 Port limpar, input, 1, is a synchronous clear request.
REQ-009 Port entrada_A, output, LARGURA, is the latched operand A driven to the calculator.
REQ-010 Port entrada_B, output, LARGURA, is the latched operand B driven to the calculator.
REQ-011 Port codigo, output, 3, is the latched operation code driven to the calculator.
REQ-012 Port saida_calc, input, LARGURA, is the combinational calculator result.
REQ-013 Port resultado, output, LARGURA, is the registered result.
REQ-014 Port resultado_valido, output, 1, means resultado is valid.
REQ-015 Port resultado_pronto, input, 1, means downstream accepts resultado.
REQ-016 Port erro, output, 1, is a one-cycle illegal-code pulse.

Function
REQ-017 An entry transfer SHALL occur on a rising edge when dado_valido and dado_pronto are both 1; dado_valido with dado_pronto low SHALL be ignored.
REQ-018 The FSM SHALL use states ESPERA_A, ESPERA_B, ESPERA_OP, EXECUTA and RESULTADO.
REQ-019 dado_pronto SHALL be 1 only in ESPERA_A, ESPERA_B and ESPERA_OP.
REQ-020 In ESPERA_A, a transfer SHALL latch dado into entrada_A and move to ESPERA_B.
REQ-021 In ESPERA_B, a transfer SHALL latch dado into entrada_B and move to ESPERA_OP.
REQ-022 In ESPERA_OP, a transfer with dado <= CODIGO_MAX, comparing the full width, SHALL latch dado[2:0] into codigo and move to EXECUTA.
REQ-023 In ESPERA_OP, a transfer with dado > CODIGO_MAX SHALL pulse erro for exactly one cycle, leave codigo unchanged and remain in ESPERA_OP.
REQ-024 EXECUTA SHALL last exactly one cycle, then register saida_calc into resultado and move to RESULTADO.
REQ-025 resultado_valido SHALL rise exactly 2 edges after the code transfer.
REQ-026 In RESULTADO, resultado_valido SHALL be 1, and resultado, entrada_A, entrada_B and codigo SHALL be held stable.
REQ-027 In RESULTADO, resultado_pronto=1 SHALL move the FSM to ESPERA_A, clear resultado_valido and set codigo to 3'b000 on the same edge.
REQ-028 entrada_A and entrada_B SHALL retain their values until overwritten, limpar or reset.
REQ-029 No arithmetic SHALL be performed in this block; resultado SHALL be saida_calc exactly as presented, including modulo-2^LARGURA wrap.
REQ-030 limpar=1 SHALL have priority over every transfer and handshake and, from any state, SHALL on the next edge go to ESPERA_A, zero entrada_A, entrada_B, codigo and resultado, and clear resultado_valido and erro.
REQ-031 erro SHALL be 0 in every cycle except the REQ-023 pulse.

Reset
REQ-032 While rst=1, the block SHALL immediately, without a clock edge, enter ESPERA_A with entrada_A=0, entrada_B=0, codigo=3'b000, resultado=0, resultado_valido=0 and erro=0.
REQ-033 Reset asserted in any state, including EXECUTA and RESULTADO, SHALL discard the operation in progress.
REQ-034 The first transfer after reset release SHALL be taken as operand A.

Structure
REQ-035 Operation-code constants (ZERAR=000, MOSTRAR_A=001, MOSTRAR_B=010, SOMAR=011, SUBTRAIR=100) and the FSM state encoding SHALL reside in shared package calculadora_pkg.
REQ-036 The block SHALL contain no sub-module; the calculator SHALL be instantiated beside it in the integration top, with saida_calc wired from the calculator output.

Verification
REQ-037 Entries 0x0F, 0x05, 0x03 -> codigo=011 and resultado=0x14 with resultado_valido=1 two edges after the code transfer.
REQ-038 Entries 0x03, 0x05, 0x04 -> resultado=0xFE (wrap).
REQ-039 Entries 0x10, 0x20, 0x07 -> one-cycle erro pulse and state stays ESPERA_OP; then entry 0x01 -> resultado=0x10.
REQ-040 resultado_pronto held low 3 cycles in RESULTADO -> resultado, resultado_valido=1 and dado_pronto=0 are all stable; resultado_pronto=1 -> ESPERA_A with codigo=000.
REQ-041 limpar after A=0xAA is latched, asserted together with dado_valido -> entry ignored, entrada_A=0x00, state ESPERA_A.
REQ-042 rst pulsed mid-cycle in RESULTADO -> all outputs zero before the next clock edge; after release, the first entry latches into entrada_A.

Source files
------------

// File: rtl/calculadora_pkg.sv
// Shared definitions for the calculator controller and the calculator beside it.
// Contents:
//   - operation codes understood by the calculator (3-bit)
//   - FSM state encoding of the controller (exposed for debug/checkers)
//   - helper telling whether a state accepts an entry
package calculadora_pkg;

  localparam logic [2:0] ZERAR     = 3'b000;
  localparam logic [2:0] MOSTRAR_A = 3'b001;
  localparam logic [2:0] MOSTRAR_B = 3'b010;
  localparam logic [2:0] SOMAR     = 3'b011;
  localparam logic [2:0] SUBTRAIR  = 3'b100;

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    EXECUTA   = 3'd3,
    RESULTADO = 3'd4
  } estado_t;

  // Only the three waiting states raise dado_pronto.
  function automatic logic aceita_entrada(input estado_t e);
    return (e == ESPERA_A) || (e == ESPERA_B) || (e == ESPERA_OP);
  endfunction

endpackage

// File: rtl/controle_calculadora_if.sv
// Bundle of the controller's entry/result handshake and calculator bus.
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both 1; valid without ready is simply ignored
// and the producer may change or drop its data freely.
//   entry side : dado / dado_valido / dado_pronto (plus limpar)
//   calc side  : entrada_A / entrada_B / codigo out, saida_calc back
//   result side: resultado / resultado_valido / resultado_pronto, erro pulse
// master = the environment driving entries and consuming results,
// slave  = the controller.
interface controle_calculadora_if #(
  parameter int LARGURA = 8
);
  logic [LARGURA-1:0] dado;
  logic               dado_valido;
  logic               dado_pronto;
  logic               limpar;
  logic [LARGURA-1:0] entrada_A;
  logic [LARGURA-1:0] entrada_B;
  logic [2:0]         codigo;
  logic [LARGURA-1:0] saida_calc;
  logic [LARGURA-1:0] resultado;
  logic               resultado_valido;
  logic               resultado_pronto;
  logic               erro;

  modport master (
    output dado, dado_valido, limpar, saida_calc, resultado_pronto,
    input  dado_pronto, entrada_A, entrada_B, codigo, resultado,
           resultado_valido, erro
  );

  modport slave (
    input  dado, dado_valido, limpar, saida_calc, resultado_pronto,
    output dado_pronto, entrada_A, entrada_B, codigo, resultado,
           resultado_valido, erro
  );
endinterface

// File: rtl/controle_calculadora.sv
// Controller for an external combinational calculator.
// Collects operand A, operand B and an operation code from a single entry
// stream, drives them to the calculator, waits one EXECUTA cycle, captures
// the calculator output and holds it until downstream accepts it.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   dado/_valido      entry value and its valid; dado_pronto = ready
//   limpar            synchronous clear, beats every handshake
//   entrada_A/B       latched operands to the calculator
//   codigo            latched operation code to the calculator
//   saida_calc        calculator output (combinational, outside this block)
//   resultado/_valido registered result and valid; resultado_pronto = ready
//   erro              one-cycle pulse on an illegal operation code
//   estado_dbg        current FSM state, for debug and checkers
module controle_calculadora
  import calculadora_pkg::*;
#(
  parameter int         LARGURA    = 8,
  parameter logic [2:0] CODIGO_MAX = 3'b100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] dado,
  input  logic               dado_valido,
  output logic               dado_pronto,
  input  logic               limpar,
  output logic [LARGURA-1:0] entrada_A,
  output logic [LARGURA-1:0] entrada_B,
  output logic [2:0]         codigo,
  input  logic [LARGURA-1:0] saida_calc,
  output logic [LARGURA-1:0] resultado,
  output logic               resultado_valido,
  input  logic               resultado_pronto,
  output logic               erro,
  output estado_t            estado_dbg
);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] entrada_a_q, entrada_a_d;
  logic [LARGURA-1:0] entrada_b_q, entrada_b_d;
  logic [2:0]         codigo_q, codigo_d;
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic               resultado_valido_q, resultado_valido_d;
  logic               erro_q, erro_d;
  logic               dado_pronto_q, dado_pronto_d;
  logic               transfer;
  logic               codigo_legal;

  assign transfer = dado_valido && dado_pronto_q;
  // Full-width compare: 0x80 must be illegal even though dado[2:0] is 000.
  assign codigo_legal = (dado <= LARGURA'(CODIGO_MAX));

  always_comb begin
    estado_d           = estado_q;
    entrada_a_d        = entrada_a_q;
    entrada_b_d        = entrada_b_q;
    codigo_d           = codigo_q;
    resultado_d        = resultado_q;
    resultado_valido_d = resultado_valido_q;
    erro_d             = 1'b0;

    if (limpar) begin
      estado_d           = ESPERA_A;
      entrada_a_d        = '0;
      entrada_b_d        = '0;
      codigo_d           = ZERAR;
      resultado_d        = '0;
      resultado_valido_d = 1'b0;
    end else begin
      unique case (estado_q)
        ESPERA_A: if (transfer) begin
          entrada_a_d = dado;
          estado_d    = ESPERA_B;
        end
        ESPERA_B: if (transfer) begin
          entrada_b_d = dado;
          estado_d    = ESPERA_OP;
        end
        ESPERA_OP: if (transfer) begin
          if (codigo_legal) begin
            codigo_d = dado[2:0];
            estado_d = EXECUTA;
          end else begin
            erro_d = 1'b1;
          end
        end
        EXECUTA: begin
          // Operands and code have been stable for a full cycle here, so the
          // calculator output is settled and can be captured.
          resultado_d        = saida_calc;
          resultado_valido_d = 1'b1;
          estado_d           = RESULTADO;
        end
        RESULTADO: if (resultado_pronto) begin
          resultado_valido_d = 1'b0;
          codigo_d           = ZERAR;
          estado_d           = ESPERA_A;
        end
        default: estado_d = ESPERA_A;
      endcase
    end

    // Ready is registered: it follows the state the FSM is entering.
    dado_pronto_d = aceita_entrada(estado_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q           <= ESPERA_A;
      entrada_a_q        <= '0;
      entrada_b_q        <= '0;
      codigo_q           <= ZERAR;
      resultado_q        <= '0;
      resultado_valido_q <= 1'b0;
      erro_q             <= 1'b0;
      dado_pronto_q      <= 1'b1;
    end else begin
      estado_q           <= estado_d;
      entrada_a_q        <= entrada_a_d;
      entrada_b_q        <= entrada_b_d;
      codigo_q           <= codigo_d;
      resultado_q        <= resultado_d;
      resultado_valido_q <= resultado_valido_d;
      erro_q             <= erro_d;
      dado_pronto_q      <= dado_pronto_d;
    end
  end

  assign dado_pronto      = dado_pronto_q;
  assign entrada_A        = entrada_a_q;
  assign entrada_B        = entrada_b_q;
  assign codigo           = codigo_q;
  assign resultado        = resultado_q;
  assign resultado_valido = resultado_valido_q;
  assign erro             = erro_q;
  assign estado_dbg       = estado_q;

endmodule

// File: tb/tb_controle_calculadora.sv
// Self-checking bench for controle_calculadora: reset, directed vector table,
// hand-written corner sequences (illegal code, back-pressure, limpar, mid-
// cycle reset) and randomized operations checked against a reference model.
module tb_controle_calculadora;
  import calculadora_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  estado_t estado_dbg;

  controle_calculadora_if #(.LARGURA(W)) bus ();

  always #5 clk = ~clk;

  controle_calculadora #(.LARGURA(W), .CODIGO_MAX(3'b100)) dut (
    .clk              (clk),
    .rst              (rst),
    .dado             (bus.dado),
    .dado_valido      (bus.dado_valido),
    .dado_pronto      (bus.dado_pronto),
    .limpar           (bus.limpar),
    .entrada_A        (bus.entrada_A),
    .entrada_B        (bus.entrada_B),
    .codigo           (bus.codigo),
    .saida_calc       (bus.saida_calc),
    .resultado        (bus.resultado),
    .resultado_valido (bus.resultado_valido),
    .resultado_pronto (bus.resultado_pronto),
    .erro             (bus.erro),
    .estado_dbg       (estado_dbg)
  );

  // Reference arithmetic of the calculator, in plain integer terms.
  function automatic logic [W-1:0] calc(input int a, input int b, input int op);
    int r;
    case (op)
      1: r = a;
      2: r = b;
      3: r = a + b;
      4: r = a - b;
      default: r = 0;
    endcase
    return W'(r & ((1 << W) - 1));
  endfunction

  // Stand-in calculator beside the controller, fed from its latched outputs.
  always_comb bus.saida_calc = calc(int'(bus.entrada_A), int'(bus.entrada_B), int'(bus.codigo));

  int vectors = 0;
  int misses  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pronto();
    int n = 0;
    while (!bus.dado_pronto && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("pronto_timeout", 32'(bus.dado_pronto), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] v);
    wait_pronto();
    bus.dado        = v;
    bus.dado_valido = 1'b1;
    tick();
    bus.dado_valido = 1'b0;
  endtask

  // Feeds A, B, code; returns just after the code-transfer edge.
  task automatic load_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] op);
    send(a);
    send(b);
    send(op);
  endtask

  task automatic release_result();
    bus.resultado_pronto = 1'b1;
    tick();
    bus.resultado_pronto = 1'b0;
    check("rel_valido", 32'(bus.resultado_valido), 32'd0);
    check("rel_codigo", 32'(bus.codigo), 32'd0);
    check("rel_pronto", 32'(bus.dado_pronto), 32'd1);
    check("rel_estado", 32'(estado_dbg), 32'(ESPERA_A));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] op;
    logic [W-1:0] exp_res;
  } vec_t;

  vec_t tabela[7];

  initial begin
    bus.dado = '0;
    bus.dado_valido = 1'b0;
    bus.limpar = 1'b0;
    bus.resultado_pronto = 1'b0;

    tabela[0] = '{8'h0F, 8'h05, 8'h03, 8'h14};
    tabela[1] = '{8'h03, 8'h05, 8'h04, 8'hFE};
    tabela[2] = '{8'hAA, 8'h55, 8'h01, 8'hAA};
    tabela[3] = '{8'hAA, 8'h55, 8'h02, 8'h55};
    tabela[4] = '{8'hAA, 8'h55, 8'h00, 8'h00};
    tabela[5] = '{8'hFF, 8'h01, 8'h03, 8'h00};
    tabela[6] = '{8'h00, 8'h01, 8'h04, 8'hFF};

    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_entrada_A", 32'(bus.entrada_A), 32'd0);
    check("rst_entrada_B", 32'(bus.entrada_B), 32'd0);
    check("rst_codigo", 32'(bus.codigo), 32'd0);
    check("rst_resultado", 32'(bus.resultado), 32'd0);
    check("rst_valido", 32'(bus.resultado_valido), 32'd0);
    check("rst_erro", 32'(bus.erro), 32'd0);
    check("rst_pronto", 32'(bus.dado_pronto), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---------------- directed table ----------------
    for (int i = 0; i < 7; i++) begin
      load_op(tabela[i].a, tabela[i].b, tabela[i].op);
      check("tab_codigo", 32'(bus.codigo), 32'(tabela[i].op[2:0]));
      check("tab_valido_early", 32'(bus.resultado_valido), 32'd0);
      check("tab_pronto_exec", 32'(bus.dado_pronto), 32'd0);
      tick();
      check("tab_valido", 32'(bus.resultado_valido), 32'd1);
      check("tab_resultado", 32'(bus.resultado), 32'(tabela[i].exp_res));
      check("tab_entrada_A", 32'(bus.entrada_A), 32'(tabela[i].a));
      check("tab_entrada_B", 32'(bus.entrada_B), 32'(tabela[i].b));
      release_result();
    end

    // ---------------- illegal code then legal ----------------
    load_op(8'h10, 8'h20, 8'h07);
    check("ill_erro", 32'(bus.erro), 32'd1);
    check("ill_codigo", 32'(bus.codigo), 32'd0);
    check("ill_estado", 32'(estado_dbg), 32'(ESPERA_OP));
    check("ill_pronto", 32'(bus.dado_pronto), 32'd1);
    tick();
    check("ill_erro_gone", 32'(bus.erro), 32'd0);
    send(8'h80);  // low bits 000, but out of range on the full width
    check("ill80_erro", 32'(bus.erro), 32'd1);
    check("ill80_estado", 32'(estado_dbg), 32'(ESPERA_OP));
    send(8'h01);
    check("ill_next_erro", 32'(bus.erro), 32'd0);
    tick();
    check("ill_resultado", 32'(bus.resultado), 32'h10);

    // ---------------- back-pressure in RESULTADO ----------------
    for (int i = 0; i < 3; i++) begin
      bus.dado        = 8'h5A;
      bus.dado_valido = 1'b1;  // must be ignored while dado_pronto is low
      tick();
      check("hold_resultado", 32'(bus.resultado), 32'h10);
      check("hold_valido", 32'(bus.resultado_valido), 32'd1);
      check("hold_pronto", 32'(bus.dado_pronto), 32'd0);
      check("hold_entrada_A", 32'(bus.entrada_A), 32'h10);
    end
    bus.dado_valido = 1'b0;
    release_result();

    // ---------------- limpar beats a transfer ----------------
    send(8'hAA);
    check("clr_pre_A", 32'(bus.entrada_A), 32'hAA);
    bus.limpar      = 1'b1;
    bus.dado        = 8'h33;
    bus.dado_valido = 1'b1;
    tick();
    bus.limpar      = 1'b0;
    bus.dado_valido = 1'b0;
    check("clr_entrada_A", 32'(bus.entrada_A), 32'd0);
    check("clr_estado", 32'(estado_dbg), 32'(ESPERA_A));
    check("clr_pronto", 32'(bus.dado_pronto), 32'd1);
    send(8'h44);
    check("clr_next_A", 32'(bus.entrada_A), 32'h44);

    // limpar while RESULTADO is holding a result
    send(8'h01);
    send(8'h03);
    tick();
    bus.limpar = 1'b1;
    tick();
    bus.limpar = 1'b0;
    check("clr_res_resultado", 32'(bus.resultado), 32'd0);
    check("clr_res_valido", 32'(bus.resultado_valido), 32'd0);
    check("clr_res_B", 32'(bus.entrada_B), 32'd0);

    // ---------------- asynchronous reset in RESULTADO ----------------
    load_op(8'h21, 8'h12, 8'h03);
    tick();
    check("pre_rst_valido", 32'(bus.resultado_valido), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_resultado", 32'(bus.resultado), 32'd0);
    check("arst_valido", 32'(bus.resultado_valido), 32'd0);
    check("arst_entrada_A", 32'(bus.entrada_A), 32'd0);
    check("arst_codigo", 32'(bus.codigo), 32'd0);
    check("arst_pronto", 32'(bus.dado_pronto), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send(8'h77);
    check("arst_first_A", 32'(bus.entrada_A), 32'h77);
    check("arst_estado", 32'(estado_dbg), 32'(ESPERA_B));
    bus.limpar = 1'b1;
    tick();
    bus.limpar = 1'b0;

    // ---------------- randomized operations ----------------
    for (int n = 0; n < 150; n++) begin
      logic [W-1:0] a, b, op, bad;
      int espera;
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      op = W'($urandom_range(0, 4));
      send(a);
      send(b);
      if ($urandom_range(0, 3) == 0) begin
        bad = W'($urandom_range(5, 255));
        send(bad);
        check("rnd_erro", 32'(bus.erro), 32'd1);
        check("rnd_erro_estado", 32'(estado_dbg), 32'(ESPERA_OP));
      end
      exp_q.push_back(calc(int'(a), int'(b), int'(op)));
      send(op);
      check("rnd_erro_clear", 32'(bus.erro), 32'd0);
      tick();
      check("rnd_valido", 32'(bus.resultado_valido), 32'd1);
      if (exp_q.size() > 0) check("rnd_resultado", 32'(bus.resultado), 32'(exp_q.pop_front()));
      espera = $urandom_range(0, 3);
      for (int k = 0; k < espera; k++) begin
        tick();
        check("rnd_hold_codigo", 32'(bus.codigo), 32'(op[2:0]));
        check("rnd_hold_valido", 32'(bus.resultado_valido), 32'd1);
      end
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
